// File: rtl/stopwatch.sv
// Event-to-event duration timer: ARM, then measure the number of prescaled ticks
// between two rising edges of event_in. All outputs are registered.
module stopwatch #(
  parameter int unsigned STOPWATCH_ADDITIONAL_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic        event_in,
  output logic [31:0] data_out,
  output logic        capture_valid,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned B  = STOPWATCH_ADDITIONAL_BITS;
  localparam int unsigned PW = (B == 0) ? 1 : B;
  // With B=0 the prescaler is pinned at zero so every cycle counts as a wrap.
  localparam logic [PW-1:0] PRE_MAX = (B == 0) ? {PW{1'b0}} : {PW{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   count_q, count_d, count_n;
  logic [PW-1:0] pre_q, pre_d, pre_n;
  logic [31:0]   data_out_q, data_out_d;
  logic          capture_valid_q, capture_valid_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic          event_prev_q, event_prev_d;
  logic          rise, arm, abort, wrap;
  logic          unused_data_in;

  assign unused_data_in = ^data_in[31:2];

  assign rise  = event_in & ~event_prev_q;
  assign arm   = write & data_in[0];
  assign abort = write & data_in[1];
  assign wrap  = (pre_q == PRE_MAX);
  assign pre_n = wrap ? '0 : pre_q + 1'b1;
  // The stop cycle itself counts, so the capture takes the incremented value.
  assign count_n = (wrap && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    pre_d           = pre_q;
    data_out_d      = data_out_q;
    capture_valid_d = capture_valid_q;
    overflow_d      = overflow_q;
    event_prev_d    = event_in;
    if (abort) begin
      state_d         = IDLE;
      count_d         = '0;
      pre_d           = '0;
      capture_valid_d = 1'b0;
    end else if (arm) begin
      state_d         = ARMED;
      count_d         = '0;
      pre_d           = '0;
      overflow_d      = 1'b0;
      capture_valid_d = 1'b0;
    end else begin
      case (state_q)
        ARMED: if (rise) begin
          state_d = RUNNING;
          count_d = '0;
          pre_d   = '0;
        end
        RUNNING: begin
          pre_d   = pre_n;
          count_d = count_n;
          if (count_n == 32'hFFFF_FFFF) overflow_d = 1'b1;
          if (rise) begin
            state_d         = DONE;
            data_out_d      = count_n;
            capture_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == RUNNING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      pre_q           <= '0;
      data_out_q      <= '0;
      capture_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
      event_prev_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      pre_q           <= pre_d;
      data_out_q      <= data_out_d;
      capture_valid_q <= capture_valid_d;
      overflow_q      <= overflow_d;
      busy_q          <= busy_d;
      event_prev_q    <= event_prev_d;
    end
  end

  assign data_out      = data_out_q;
  assign capture_valid = capture_valid_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench: eight stopwatches (prescaler B=0..7) share one stimulus stream;
// lane g is expected to report floor(gap / 2^g).
module tb_stopwatch;
  localparam int NL = 8;
  localparam logic [31:0] ARM   = 32'h1;
  localparam logic [31:0] ABORT = 32'h2;

  logic        clk = 1'b0;
  logic        rst, write, event_in;
  logic [31:0] data_in;
  logic [31:0] dout [NL];
  logic        cv   [NL];
  logic        ov   [NL];
  logic        bsy  [NL];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    stopwatch #(.STOPWATCH_ADDITIONAL_BITS(g)) u_dut (
      .clk(clk), .rst(rst), .write(write), .data_in(data_in), .event_in(event_in),
      .data_out(dout[g]), .capture_valid(cv[g]), .overflow(ov[g]), .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] w);
    write = 1'b1; data_in = w;
    tick();
    write = 1'b0; data_in = '0;
  endtask

  task automatic edge_pulse();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
  endtask

  // ARM, start edge, stop edge `gap` cycles later.
  task automatic measure(input int gap);
    cmd(ARM);
    repeat (3) tick();
    edge_pulse();
    repeat (gap - 1) tick();
    edge_pulse();
  endtask

  task automatic chk_all_lanes(input string tag, input int gap);
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("%s_dout_b%0d", tag, g), dout[g], 32'(gap >> g));
      chk($sformatf("%s_cv_b%0d", tag, g), {31'b0, cv[g]}, 32'd1);
      chk($sformatf("%s_busy_b%0d", tag, g), {31'b0, bsy[g]}, 32'd0);
    end
  endtask

  initial begin
    int gaps [4];
    gaps = '{1000, 517, 2048, 3};
    rst = 1'b1; write = 1'b0; data_in = '0; event_in = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("rst_dout_b%0d", g), dout[g], 32'd0);
      chk($sformatf("rst_cv_b%0d", g), {31'b0, cv[g]}, 32'd0);
      chk($sformatf("rst_ov_b%0d", g), {31'b0, ov[g]}, 32'd0);
      chk($sformatf("rst_busy_b%0d", g), {31'b0, bsy[g]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    // Edge in IDLE is ignored
    edge_pulse();
    chk("idle_edge_busy", {31'b0, bsy[0]}, 32'd0);

    // Basic 100-cycle measurement
    cmd(ARM);
    chk("arm_busy", {31'b0, bsy[0]}, 32'd1);
    repeat (5) tick();
    edge_pulse();
    repeat (99) tick();
    edge_pulse();
    chk("m100_dout", dout[0], 32'd100);
    chk("m100_cv", {31'b0, cv[0]}, 32'd1);
    chk("m100_ov", {31'b0, ov[0]}, 32'd0);
    chk("m100_busy", {31'b0, bsy[0]}, 32'd0);
    chk("m100_dout_b3", dout[3], 32'd12);

    // B=3 cases
    measure(803);
    chk("m803_dout_b3", dout[3], 32'd100);
    chk("m803_dout_b0", dout[0], 32'd803);
    measure(7);
    chk("m7_dout_b3", dout[3], 32'd0);
    chk("m7_cv_b3", {31'b0, cv[3]}, 32'd1);
    chk("m7_dout_b0", dout[0], 32'd7);

    // Rise in DONE ignored; no-op write ignored
    edge_pulse();
    tick();
    cmd(32'hFFFF_FFFC);
    chk("done_edge_dout", dout[0], 32'd7);
    chk("done_edge_cv", {31'b0, cv[0]}, 32'd1);

    // ABORT mid-run
    cmd(ARM);
    edge_pulse();
    repeat (50) tick();
    cmd(ABORT | ARM);
    chk("abort_busy", {31'b0, bsy[0]}, 32'd0);
    chk("abort_cv", {31'b0, cv[0]}, 32'd0);
    chk("abort_dout", dout[0], 32'd7);
    edge_pulse();
    repeat (4) tick();
    edge_pulse();
    chk("abort_post_busy", {31'b0, bsy[0]}, 32'd0);
    chk("abort_post_cv", {31'b0, cv[0]}, 32'd0);
    chk("abort_post_dout", dout[0], 32'd7);

    // ARM coincident with an edge: edge ignored
    write = 1'b1; data_in = ARM; event_in = 1'b1;
    tick();
    write = 1'b0; data_in = '0; event_in = 1'b0;
    repeat (8) tick();
    edge_pulse();
    repeat (19) tick();
    edge_pulse();
    chk("coinc_dout", dout[0], 32'd20);
    chk("coinc_cv", {31'b0, cv[0]}, 32'd1);

    // event_in held high is a single edge
    cmd(ARM);
    event_in = 1'b1;
    tick();
    repeat (30) tick();
    chk("held_busy", {31'b0, bsy[0]}, 32'd1);
    chk("held_cv", {31'b0, cv[0]}, 32'd0);
    event_in = 1'b0;
    tick();
    edge_pulse();
    chk("held_dout", dout[0], 32'd32);
    chk("held_dout_b3", dout[3], 32'd4);

    // Re-ARM while RUNNING restarts
    cmd(ARM);
    edge_pulse();
    repeat (10) tick();
    cmd(ARM);
    chk("rearm_busy", {31'b0, bsy[0]}, 32'd1);
    repeat (2) tick();
    edge_pulse();
    repeat (4) tick();
    edge_pulse();
    chk("rearm_dout", dout[0], 32'd5);

    // Gap sweep across all prescaler widths
    for (int i = 0; i < 4; i++) begin
      measure(gaps[i]);
      chk_all_lanes($sformatf("sweep%0d", gaps[i]), gaps[i]);
    end

    // Asynchronous reset while RUNNING with event_in high
    cmd(ARM);
    event_in = 1'b1;
    tick();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", dout[0], 32'd0);
    chk("arst_cv", {31'b0, cv[0]}, 32'd0);
    chk("arst_ov", {31'b0, ov[0]}, 32'd0);
    chk("arst_busy", {31'b0, bsy[0]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    cmd(ARM);
    repeat (3) tick();
    chk("arst_high_busy", {31'b0, bsy[0]}, 32'd1);
    event_in = 1'b0;
    tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    repeat (9) tick();
    edge_pulse();
    chk("arst_meas_dout", dout[0], 32'd10);
    chk("arst_meas_cv", {31'b0, cv[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stopwatch.md
STOPWATCH -- requirements
Module: stopwatch

Interface
REQ-001 Parameter STOPWATCH_ADDITIONAL_BITS, default 0, prescaler width B: one count tick per 2^B clock cycles; legal range 0..7.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 write  input  1  command strobe, one cycle; data_in sampled when high.
REQ-005 data_in  input  32  command word: bit0 ARM, bit1 ABORT, bits31:2 ignored.
REQ-006 event_in  input  1  measured signal, synchronous to clk; rising edges start and stop measurement.
REQ-007 data_out  output  32  last captured duration in ticks.
REQ-008 capture_valid  output  1  level; high while a fresh capture is held.
REQ-009 overflow  output  1  sticky; last measurement saturated.
REQ-010 busy  output  1  high in ARMED or RUNNING.

Function
REQ-011 States: IDLE, ARMED, RUNNING, DONE; registered outputs, no combinational path from inputs to outputs.
REQ-012 Edge detect: rise = event_in & ~event_prev; event_prev updates every cycle in every state.
REQ-013 IDLE: write with ARM=1, ABORT=0 -> ARMED; count, prescaler, overflow, capture_valid cleared; data_out unchanged.
REQ-014 ARMED: rise -> RUNNING next cycle, prescaler=0, count=0.
REQ-015 RUNNING: prescaler increments each cycle; on wrap from 2^B-1 to 0, count increments (B=0: every cycle).
REQ-016 RUNNING: rise -> DONE; data_out = floor((t_stop - t_start) / 2^B), t_start/t_stop = cycles where start/stop rise was sampled; capture_valid=1 on the following cycle.
REQ-017 count saturates at 32'hFFFF_FFFF; reaching saturation sets overflow, which is held until next ARM or reset; data_out captures saturated value.
REQ-018 DONE: holds data_out, capture_valid, overflow; rise ignored; ARM -> ARMED per REQ-013.
REQ-019 ABORT=1 in any state -> IDLE next cycle; count cleared; data_out retained; capture_valid cleared; ABORT beats ARM in the same word.
REQ-020 ARM while ARMED or RUNNING restarts: -> ARMED, count/prescaler cleared, measurement discarded.
REQ-021 write and rise in the same cycle: write is applied, rise ignored.
REQ-022 rise in IDLE ignored; event_in held high never counts as an edge.
REQ-023 busy = (state == ARMED or RUNNING), registered with state.
REQ-024 data_in with ARM=0, ABORT=0 under write: no effect.

Reset
REQ-025 While rst is high: state IDLE, data_out=0, capture_valid=0, overflow=0, busy=0, count=0, prescaler=0, event_prev=1.
REQ-026 Reset asserted mid-measurement discards it immediately and asynchronously; after release, no edge is detected until event_in goes low then high.

Verification
REQ-027 B=0: ARM, rise at cycle 10, rise at cycle 110 -> data_out=100, capture_valid=1, overflow=0, busy=0.
REQ-028 B=3: ARM, edges 803 cycles apart -> data_out=100; edges 7 apart -> data_out=0, capture_valid=1.
REQ-029 Loop-back, all B=0..7: Timer (same B) loaded with random N in 0..2000 drives event_in high at load and on interrupt -> data_out equals N, 20 runs per B.
REQ-030 B=0: ARM, start edge, ABORT after 50 cycles, further edges -> state IDLE, capture_valid=0, data_out retains previous value, busy=0.
REQ-031 write(ARM) coincident with start edge -> edge ignored; next edge starts; second edge 20 later -> data_out=20.
REQ-032 rst pulsed while RUNNING with event_in high -> all outputs 0; release, re-ARM, event_in low 1 cycle then high -> measurement starts.
